// File: rtl/ooo_reg_scoreboard_if.sv
// rtl/ooo_reg_scoreboard_if.sv - dispatch, lookup, writeback and status bundle for the register scoreboard
interface ooo_reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int TAG_W    = 4,
  parameter int NUM_WB   = 2
);
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic                    dispatch_valid;
  logic                    dispatch_wen;
  logic [REG_W-1:0]        dispatch_rd;
  logic [TAG_W-1:0]        dispatch_tag;
  logic                    use_rs1;
  logic                    use_rs2;
  logic [REG_W-1:0]        rs1;
  logic [REG_W-1:0]        rs2;
  logic                    stall;
  logic                    flush;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*REG_W-1:0] wb_rd;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic                    rd_busy;
  logic [TAG_W-1:0]        rs1_tag;
  logic [TAG_W-1:0]        rs2_tag;
  logic                    hazard;
  logic [CNT_W-1:0]        busy_count;

  modport master (
    output dispatch_valid, dispatch_wen, dispatch_rd, dispatch_tag,
    output use_rs1, use_rs2, rs1, rs2, stall, flush,
    output wb_valid, wb_rd, wb_tag,
    input  rs1_busy, rs2_busy, rd_busy, rs1_tag, rs2_tag, hazard, busy_count
  );

  modport slave (
    input  dispatch_valid, dispatch_wen, dispatch_rd, dispatch_tag,
    input  use_rs1, use_rs2, rs1, rs2, stall, flush,
    input  wb_valid, wb_rd, wb_tag,
    output rs1_busy, rs2_busy, rd_busy, rs1_tag, rs2_tag, hazard, busy_count
  );
endinterface

// File: rtl/ooo_reg_scoreboard.sv
// rtl/ooo_reg_scoreboard.sv - per-register busy bit and producer tag table with writeback bypass
module ooo_reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 5,
  parameter int TAG_W     = 4,
  parameter int NUM_WB    = 2,
  parameter bit WAW_STALL = 1'b1
) (
  input logic                 CLK,
  input logic                 nRST,
  ooo_reg_scoreboard_if.slave sb
);
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic [NUM_REGS-1:0]            busy_q, busy_n, wb_hit, live;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_n;
  logic [CNT_W-1:0]               count_q, count_n;
  logic                           rs1_busy, rs2_busy, rd_busy, hazard, accept;

  function automatic logic pick_busy(input logic [REG_W-1:0] idx, input logic [NUM_REGS-1:0] vec);
    pick_busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++)
      if (idx == REG_W'(r)) pick_busy = vec[r];
  endfunction

  function automatic logic [TAG_W-1:0] pick_tag(input logic [REG_W-1:0] idx,
                                                input logic [NUM_REGS-1:0][TAG_W-1:0] tags);
    pick_tag = '0;
    for (int r = 1; r < NUM_REGS; r++)
      if (idx == REG_W'(r)) pick_tag = tags[r];
  endfunction

  // A writeback only hits when its tag matches the current producer, so stale WAW results fall through.
  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < NUM_WB; p++)
      for (int r = 1; r < NUM_REGS; r++)
        if (sb.wb_valid[p] && sb.wb_rd[p*REG_W +: REG_W] == REG_W'(r) &&
            sb.wb_tag[p*TAG_W +: TAG_W] == tag_q[r])
          wb_hit[r] = 1'b1;
  end

  assign live     = busy_q & ~wb_hit;
  assign rs1_busy = sb.use_rs1 & pick_busy(sb.rs1, live);
  assign rs2_busy = sb.use_rs2 & pick_busy(sb.rs2, live);
  assign rd_busy  = sb.dispatch_wen & pick_busy(sb.dispatch_rd, live);
  assign hazard   = rs1_busy | rs2_busy | (WAW_STALL & rd_busy);
  assign accept   = sb.dispatch_valid & sb.dispatch_wen & ~sb.stall & ~hazard & ~sb.flush;

  // Priority: flush over dispatch set over writeback clear.
  always_comb begin
    busy_n = busy_q & ~wb_hit;
    tag_n  = tag_q;
    for (int r = 1; r < NUM_REGS; r++)
      if (accept && sb.dispatch_rd == REG_W'(r)) begin
        busy_n[r] = 1'b1;
        tag_n[r]  = sb.dispatch_tag;
      end
    if (sb.flush) busy_n = '0;
    busy_n[0] = 1'b0;
    count_n = '0;
    for (int r = 0; r < NUM_REGS; r++)
      count_n = count_n + CNT_W'(busy_n[r]);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      busy_q  <= '0;
      tag_q   <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_n;
      tag_q   <= tag_n;
      count_q <= count_n;
    end
  end

  assign sb.rs1_busy   = rs1_busy;
  assign sb.rs2_busy   = rs2_busy;
  assign sb.rd_busy    = rd_busy;
  assign sb.rs1_tag    = rs1_busy ? pick_tag(sb.rs1, tag_q) : '0;
  assign sb.rs2_tag    = rs2_busy ? pick_tag(sb.rs2, tag_q) : '0;
  assign sb.hazard     = hazard;
  assign sb.busy_count = count_q;
endmodule

// File: tb/tb_ooo_reg_scoreboard.sv
// tb/tb_ooo_reg_scoreboard.sv - two scoreboards (WAW stall on/off) against a table-level reference model
module tb_ooo_reg_scoreboard;
  logic clk;
  logic nrst;
  logic dv, dwen, urs1, urs2, stall, flush;
  logic [4:0] drd, rs1, rs2;
  logic [3:0] dtag;
  logic       wbv [2];
  logic [4:0] wbrd [2];
  logic [3:0] wbtag [2];

  logic       o_rs1b [2], o_rs2b [2], o_rdb [2], o_haz [2];
  logic [3:0] o_rs1t [2], o_rs2t [2];
  logic [5:0] o_cnt [2];

  bit       m_busy [2][32];
  bit [3:0] m_tag [2][32];
  int checks = 0;
  int errors = 0;

  ooo_reg_scoreboard_if #(.NUM_REGS(32), .REG_W(5), .TAG_W(4), .NUM_WB(2)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].dispatch_valid = dv;
    assign bus[g].dispatch_wen   = dwen;
    assign bus[g].dispatch_rd    = drd;
    assign bus[g].dispatch_tag   = dtag;
    assign bus[g].use_rs1        = urs1;
    assign bus[g].use_rs2        = urs2;
    assign bus[g].rs1            = rs1;
    assign bus[g].rs2            = rs2;
    assign bus[g].stall          = stall;
    assign bus[g].flush          = flush;
    assign bus[g].wb_valid       = {wbv[1], wbv[0]};
    assign bus[g].wb_rd          = {wbrd[1], wbrd[0]};
    assign bus[g].wb_tag         = {wbtag[1], wbtag[0]};
    assign o_rs1b[g] = bus[g].rs1_busy;
    assign o_rs2b[g] = bus[g].rs2_busy;
    assign o_rdb[g]  = bus[g].rd_busy;
    assign o_rs1t[g] = bus[g].rs1_tag;
    assign o_rs2t[g] = bus[g].rs2_tag;
    assign o_haz[g]  = bus[g].hazard;
    assign o_cnt[g]  = bus[g].busy_count;

    ooo_reg_scoreboard #(.NUM_REGS(32), .REG_W(5), .TAG_W(4), .NUM_WB(2), .WAW_STALL(g == 0)) dut (
      .CLK (clk),
      .nRST(nrst),
      .sb  (bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 stalls on WAW, instance 1 renames.
  function automatic bit m_waw(int k);
    return k == 0;
  endfunction

  function automatic bit m_wb_match(int k, logic [4:0] r);
    for (int p = 0; p < 2; p++)
      if (wbv[p] && wbrd[p] == r && wbtag[p] == m_tag[k][r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_lookup(int k, logic use_it, logic [4:0] r);
    return use_it && r != 0 && m_busy[k][r] && !m_wb_match(k, r);
  endfunction

  function automatic bit m_hazard(int k);
    return m_lookup(k, urs1, rs1) || m_lookup(k, urs2, rs2) || (m_waw(k) && m_lookup(k, dwen, drd));
  endfunction

  function automatic int m_count(int k);
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[k][r]);
    return c;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit nb [32];
      bit acc;
      acc = dv && dwen && !stall && !flush && drd != 0 && !m_hazard(k);
      for (int r = 0; r < 32; r++) nb[r] = m_busy[k][r];
      for (int p = 0; p < 2; p++)
        if (wbv[p] && wbrd[p] != 0 && m_busy[k][wbrd[p]] && m_tag[k][wbrd[p]] == wbtag[p])
          nb[wbrd[p]] = 1'b0;
      if (acc) begin
        nb[drd] = 1'b1;
        m_tag[k][drd] = dtag;
      end
      for (int r = 0; r < 32; r++) m_busy[k][r] = flush ? 1'b0 : nb[r];
      if (!nrst)
        for (int r = 0; r < 32; r++) begin
          m_busy[k][r] = 1'b0;
          m_tag[k][r]  = '0;
        end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    dv = 0; dwen = 0; drd = 0; dtag = 0; urs1 = 0; urs2 = 0; rs1 = 0; rs2 = 0;
    stall = 0; flush = 0;
    for (int p = 0; p < 2; p++) begin wbv[p] = 0; wbrd[p] = 0; wbtag[p] = 0; end
  endtask

  task automatic test_reset();
    idle();
    nrst = 0;
    step();
    step();
    nrst = 1;
    urs1 = 1; rs1 = 5; urs2 = 1; rs2 = 9; dwen = 1; drd = 3;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_rs1b[k] !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy[%0d]: got %b want 0", k, o_rs1b[k]); end
      checks++; if (o_rs2b[k] !== 1'b0) begin errors++; $display("FAIL reset_rs2_busy[%0d]: got %b want 0", k, o_rs2b[k]); end
      checks++; if (o_rdb[k] !== 1'b0 || o_haz[k] !== 1'b0) begin errors++; $display("FAIL reset_rd_haz[%0d]: got %b%b want 00", k, o_rdb[k], o_haz[k]); end
      checks++; if (o_rs1t[k] !== 4'd0 || o_rs2t[k] !== 4'd0) begin errors++; $display("FAIL reset_tags[%0d]: got %h %h want 0 0", k, o_rs1t[k], o_rs2t[k]); end
      checks++; if (o_cnt[k] !== 6'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d want 0", k, o_cnt[k]); end
    end
  endtask

  task automatic test_dispatch_bypass();
    idle(); dv = 1; dwen = 1; drd = 5; dtag = 3;
    #1;
    checks++; if (o_haz[0] !== 1'b0) begin errors++; $display("FAIL disp_first_hazard: got %b want 0", o_haz[0]); end
    step();
    idle(); urs1 = 1; rs1 = 5;
    #1;
    checks++; if (o_rs1b[0] !== 1'b1) begin errors++; $display("FAIL disp_rs1_busy: got %b want 1", o_rs1b[0]); end
    checks++; if (o_rs1t[0] !== 4'd3) begin errors++; $display("FAIL disp_rs1_tag: got %0d want 3", o_rs1t[0]); end
    checks++; if (o_haz[0] !== 1'b1) begin errors++; $display("FAIL disp_hazard: got %b want 1", o_haz[0]); end
    checks++; if (o_cnt[0] !== 6'd1) begin errors++; $display("FAIL disp_count: got %0d want 1", o_cnt[0]); end
    wbv[1] = 1; wbrd[1] = 5; wbtag[1] = 3;
    #1;
    checks++; if (o_rs1b[0] !== 1'b0 || o_rs1t[0] !== 4'd0) begin errors++; $display("FAIL bypass_rs1: got %b/%0d want 0/0", o_rs1b[0], o_rs1t[0]); end
    checks++; if (o_haz[0] !== 1'b0) begin errors++; $display("FAIL bypass_hazard: got %b want 0", o_haz[0]); end
    step();
    idle();
    #1;
    checks++; if (o_cnt[0] !== 6'd0 || o_cnt[1] !== 6'd0) begin errors++; $display("FAIL bypass_count: got %0d %0d want 0 0", o_cnt[0], o_cnt[1]); end
  endtask

  task automatic test_waw();
    idle(); dv = 1; dwen = 1; drd = 7; dtag = 2;
    step();
    idle(); dv = 1; dwen = 1; drd = 7; dtag = 9;
    #1;
    checks++; if (o_rdb[1] !== 1'b1 || o_haz[1] !== 1'b0) begin errors++; $display("FAIL waw_rename_haz: got rd_busy=%b hazard=%b want 1 0", o_rdb[1], o_haz[1]); end
    checks++; if (o_haz[0] !== 1'b1) begin errors++; $display("FAIL waw_stall_haz: got %b want 1", o_haz[0]); end
    step();
    idle(); wbv[0] = 1; wbrd[0] = 7; wbtag[0] = 2; urs1 = 1; rs1 = 7;
    #1;
    checks++; if (o_rs1b[1] !== 1'b1 || o_rs1t[1] !== 4'd9) begin errors++; $display("FAIL waw_stale_wb: got %b/%0d want 1/9", o_rs1b[1], o_rs1t[1]); end
    checks++; if (o_rs1b[0] !== 1'b0) begin errors++; $display("FAIL waw_stall_wb: got %b want 0", o_rs1b[0]); end
    step();
    idle();
    #1;
    checks++; if (o_cnt[1] !== 6'd1 || o_cnt[0] !== 6'd0) begin errors++; $display("FAIL waw_count: got %0d %0d want 0 1", o_cnt[0], o_cnt[1]); end
    wbv[1] = 1; wbrd[1] = 7; wbtag[1] = 9;
    step();
    idle();
    #1;
    checks++; if (o_cnt[1] !== 6'd0) begin errors++; $display("FAIL waw_final_clear: got %0d want 0", o_cnt[1]); end
  endtask

  task automatic test_reg_zero();
    idle(); dv = 1; dwen = 1; drd = 0; dtag = 6; urs1 = 1; rs1 = 0;
    #1;
    checks++; if (o_rs1b[0] !== 1'b0 || o_haz[0] !== 1'b0) begin errors++; $display("FAIL zero_lookup: got %b%b want 00", o_rs1b[0], o_haz[0]); end
    step();
    idle();
    #1;
    checks++; if (o_cnt[0] !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", o_cnt[0]); end
  endtask

  task automatic test_fill_flush();
    for (int r = 1; r < 32; r++) begin
      idle(); dv = 1; dwen = 1; drd = 5'(r); dtag = 4'(r);
      step();
    end
    idle();
    #1;
    checks++; if (o_cnt[0] !== 6'd31 || o_cnt[1] !== 6'd31) begin errors++; $display("FAIL fill_count: got %0d %0d want 31 31", o_cnt[0], o_cnt[1]); end
    flush = 1; dv = 1; dwen = 1; drd = 4; dtag = 5; urs1 = 1; rs1 = 4;
    #1;
    checks++; if (o_rs1b[0] !== 1'b1 || o_rs1t[0] !== 4'd4) begin errors++; $display("FAIL flush_old_view: got %b/%0d want 1/4", o_rs1b[0], o_rs1t[0]); end
    step();
    idle(); urs1 = 1; rs1 = 4;
    #1;
    checks++; if (o_rs1b[1] !== 1'b0 || o_rs1b[0] !== 1'b0) begin errors++; $display("FAIL flush_rd4: got %b %b want 0 0", o_rs1b[0], o_rs1b[1]); end
    checks++; if (o_cnt[0] !== 6'd0 || o_cnt[1] !== 6'd0) begin errors++; $display("FAIL flush_count: got %0d %0d want 0 0", o_cnt[0], o_cnt[1]); end
  endtask

  task automatic test_same_cycle_and_mid_reset();
    idle(); dv = 1; dwen = 1; drd = 10; dtag = 5;
    step();
    idle(); dv = 1; dwen = 1; drd = 10; dtag = 1; wbv[0] = 1; wbrd[0] = 10; wbtag[0] = 5;
    #1;
    checks++; if (o_haz[0] !== 1'b0) begin errors++; $display("FAIL same_hazard: got %b want 0", o_haz[0]); end
    step();
    idle(); urs1 = 1; rs1 = 10;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_rs1b[k] !== 1'b1 || o_rs1t[k] !== 4'd1) begin errors++; $display("FAIL same_entry[%0d]: got %b/%0d want 1/1", k, o_rs1b[k], o_rs1t[k]); end
      checks++; if (o_cnt[k] !== 6'd1) begin errors++; $display("FAIL same_count[%0d]: got %0d want 1", k, o_cnt[k]); end
    end
    idle(); dv = 1; dwen = 1; drd = 12; dtag = 4;
    step();
    nrst = 0; drd = 13; dtag = 7; wbv[0] = 1; wbrd[0] = 10; wbtag[0] = 1;
    step();
    nrst = 1;
    idle(); urs1 = 1; rs1 = 12; urs2 = 1; rs2 = 10; dwen = 1; drd = 13;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if ({o_rs1b[k], o_rs2b[k], o_rdb[k], o_haz[k]} !== 4'b0) begin errors++; $display("FAIL midreset_flags[%0d]: got %b%b%b%b want 0000", k, o_rs1b[k], o_rs2b[k], o_rdb[k], o_haz[k]); end
      checks++; if (o_cnt[k] !== 6'd0) begin errors++; $display("FAIL midreset_count[%0d]: got %0d want 0", k, o_cnt[k]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      nrst  = ($urandom_range(0, 99) != 0);
      dv    = ($urandom_range(0, 3) != 0);
      dwen  = ($urandom_range(0, 4) != 0);
      drd   = 5'($urandom_range(0, 7));
      dtag  = 4'($urandom_range(0, 3));
      urs1  = 1'($urandom);
      urs2  = 1'($urandom);
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 2; p++) begin
        int kk;
        kk = int'($urandom_range(0, 1));
        wbv[p]   = 1'($urandom);
        wbrd[p]  = 5'($urandom_range(0, 7));
        wbtag[p] = ($urandom_range(0, 3) != 0) ? m_tag[kk][wbrd[p]] : 4'($urandom_range(0, 3));
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        bit e1, e2, ed;
        e1 = m_lookup(k, urs1, rs1);
        e2 = m_lookup(k, urs2, rs2);
        ed = m_lookup(k, dwen, drd);
        checks++; if (o_rs1b[k] !== e1 || o_rs1t[k] !== (e1 ? m_tag[k][rs1] : 4'd0)) begin errors++; $display("FAIL rand_rs1[%0d] n=%0d: got %b/%0d want %b/%0d", k, n, o_rs1b[k], o_rs1t[k], e1, e1 ? m_tag[k][rs1] : 4'd0); end
        checks++; if (o_rs2b[k] !== e2 || o_rs2t[k] !== (e2 ? m_tag[k][rs2] : 4'd0)) begin errors++; $display("FAIL rand_rs2[%0d] n=%0d: got %b/%0d want %b/%0d", k, n, o_rs2b[k], o_rs2t[k], e2, e2 ? m_tag[k][rs2] : 4'd0); end
        checks++; if (o_rdb[k] !== ed || o_haz[k] !== m_hazard(k)) begin errors++; $display("FAIL rand_rd_haz[%0d] n=%0d: got %b%b want %b%b", k, n, o_rdb[k], o_haz[k], ed, m_hazard(k)); end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        checks++; if (o_cnt[k] !== 6'(m_count(k))) begin errors++; $display("FAIL rand_count[%0d] n=%0d: got %0d want %0d", k, n, o_cnt[k], m_count(k)); end
      end
    end
    nrst = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_dispatch_bypass();
    test_waw();
    test_reg_zero();
    test_fill_flush();
    test_same_cycle_and_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ooo_reg_scoreboard.md
# ooo_reg_scoreboard

Parametrised register-busy scoreboard for the out-of-order core. It sits between decode and the hazard unit and replaces the single-bit rs1/rs2/rd busy flags with a per-register busy bit plus the producing ROB tag. Multiple writeback ports clear entries, and flush and WAW-stall modes are configurable. The hazard unit consumes `hazard` to stall fetch/decode.

## Interface

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hardwired never-busy.
- REG_W, 5, register index width; NUM_REGS ≤ 2^REG_W.
- TAG_W, 4, ROB tag width.
- NUM_WB, 2, number of writeback clear ports.
- WAW_STALL, 1, when 1 a busy rd raises `hazard`; when 0 the new writer overwrites the tag.

Ports:
- CLK  in  1  core clock.
- nRST  in  1  reset, synchronous, active-low.
- dispatch_valid  in  1  instruction is leaving decode this cycle.
- dispatch_wen  in  1  instruction writes rd.
- dispatch_rd  in  REG_W  destination register.
- dispatch_tag  in  TAG_W  ROB tag allocated to the instruction.
- use_rs1, use_rs2  in  1 each  instruction reads the source.
- rs1, rs2  in  REG_W each  source register indices.
- stall  in  1  hazard-unit stall; a dispatch is ignored while this is high.
- flush  in  1  execute/commit flush; clears the whole table.
- wb_valid  in  NUM_WB  per-port writeback valid.
- wb_rd  in  NUM_WB*REG_W  per-port register, packed with port 0 in the LSBs.
- wb_tag  in  NUM_WB*TAG_W  per-port producing tag, packed the same way.
- rs1_busy, rs2_busy, rd_busy  out  1 each  lookup results.
- rs1_tag, rs2_tag  out  TAG_W each  producer tag; 0 when the source is not busy.
- hazard  out  1  dispatch must stall.
- busy_count  out  $clog2(NUM_REGS+1)  registered count of busy entries.

## Operation

- State: `busy[NUM_REGS]` and `tag[NUM_REGS][TAG_W]`, both registered.
- Lookup is combinational from the current state, with same-cycle writeback bypass:
  - rsX_busy = use_rsX & rsX≠0 & busy[rsX] & no wb port has (wb_valid, wb_rd==rsX, wb_tag==tag[rsX]).
  - rd_busy follows the same rule for dispatch_rd & dispatch_wen.
  - The bypass applies to the lookup outputs only; the clear itself still happens at the clock edge.
- hazard = rs1_busy | rs2_busy | (WAW_STALL & rd_busy).
- An accepted dispatch is dispatch_valid & dispatch_wen & ~stall & ~hazard & ~flush & dispatch_rd≠0. It sets busy[rd]=1 and tag[rd]=dispatch_tag.
- Writeback port i clears busy[wb_rd_i] only if the entry is busy and its tag equals wb_tag_i. A stale writeback from a WAW-renamed older producer is ignored.
- Simultaneous events, in priority order: reset > flush > dispatch set > writeback clear.
  - If a dispatch and a writeback target the same register in one cycle, the entry ends busy with the new tag.
  - Multiple wb ports hitting the same register are legal; the effect is idempotent.
  - wb_rd==0 has no effect.
- Flush: on the next edge all busy bits are 0. A dispatch presented in the flush cycle is dropped.
- busy_count is popcount(busy) of the next state, registered. It is never greater than NUM_REGS-1.
- Tags: any TAG_W value is valid, including 0. A busy entry holding tag 0 is distinguished from a free entry by its busy bit.

## Timing

- Reset (nRST low at an edge): all busy and tag entries are 0 and busy_count=0. Lookup outputs are then 0 for any inputs.
- Reset asserted mid-operation discards all entries at that edge, with no partial clears.
- A dispatch set becomes visible to lookups 1 cycle after acceptance.
- A writeback clear is visible the same cycle through the bypass, and in state after 1 cycle.
- Flush takes effect in state 1 cycle later. Lookups during the flush cycle still reflect the old state.
- Lookups have zero latency (combinational). busy_count lags the state by 0 cycles because it is computed from the next state.
- There is no handshake beyond stall/hazard. The block never back-pressures writeback.

## Test plan

- Reset, then dispatch rd=5 tag=3. The next cycle, lookup rs1=5 -> rs1_busy=1, rs1_tag=3, hazard=1, busy_count=1.
- wb_valid[1]=1, wb_rd=5, wb_tag=3 in the same cycle as lookup rs1=5 -> rs1_busy=0 (bypass). The next cycle busy_count=0.
- WAW_STALL=0: dispatch rd=7 tag=2, then rd=7 tag=9. wb rd=7 tag=2 -> the entry stays busy with tag 9. wb tag=9 -> the entry clears.
- Dispatch rd=0 with use_rs1, rs1=0 -> nothing is set, rs1_busy=0, busy_count=0.
- Fill registers 1..31 -> busy_count=31. Assert flush together with a dispatch rd=4 -> the next cycle busy_count=0 and rd 4 is not busy.
- Same cycle: dispatch rd=10 tag=1 and wb rd=10 with the old tag -> the entry ends busy with tag 1. Then pull nRST low mid-sequence -> all outputs 0 at the next edge.
